// File: rtl/branch_resolve_ex.sv
// Execute-stage branch/jump resolution with registered redirect and wrong-path squash.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_ex #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_in_valid,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_is_branch,
    input  logic            i_is_jal,
    input  logic            i_is_jalr,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_pred_taken,
    input  logic [XLEN-1:0] i_pred_target,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_resolved_valid,
    output logic            o_resolved_taken,
    output logic [XLEN-1:0] o_resolved_pc,
    output logic [XLEN-1:0] o_link_data,
    output logic            o_illegal_cond,
    output logic [31:0]     o_branch_cnt,
    output logic [31:0]     o_mispredict_cnt
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Comparator: one subtractor gives equality, carry-based ltu and signed lt.
    logic [XLEN:0]   w_diff;
    logic            w_carry;
    logic            w_eq;
    logic            w_ltu;
    logic            w_lt;
    logic            w_cond;
    logic            w_illegal;
    logic            w_taken;
    logic [XLEN-1:0] w_pc_plus_imm;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_next_pc;
    logic            w_target_miss;
    logic            w_mispredict;
    logic            w_capture;

    assign w_diff  = {1'b0, i_rs1_data} + {1'b0, ~i_rs2_data} + {{XLEN{1'b0}}, 1'b1};
    assign w_carry = w_diff[XLEN];
    assign w_eq    = (w_diff[XLEN-1:0] == '0);
    assign w_ltu   = ~w_carry;
    assign w_lt    = (i_rs1_data[XLEN-1] & ~i_rs2_data[XLEN-1])
                   | (~(i_rs1_data[XLEN-1] ^ i_rs2_data[XLEN-1]) & ~w_carry);

    always_comb begin
        // NOTE: default first so every path assigns w_cond and no latch is inferred.
        w_cond = 1'b0;
        case (i_funct3)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = ~w_eq;
            3'b100:  w_cond = w_lt;
            3'b101:  w_cond = ~w_lt;
            3'b110:  w_cond = w_ltu;
            3'b111:  w_cond = ~w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_illegal = i_is_branch & (i_funct3[2:1] == 2'b01);
    assign w_taken   = i_is_jal | i_is_jalr | (i_is_branch & w_cond);

    assign w_pc_plus_imm = i_pc + i_imm;
    assign w_jalr_sum    = i_rs1_data + i_imm;
    assign w_target      = i_is_jalr ? (w_jalr_sum & ~XLEN'(1)) : w_pc_plus_imm;
    assign w_pc_plus4    = i_pc + XLEN'(4);
    assign w_next_pc     = w_taken ? w_target : w_pc_plus4;

    // A correctly predicted direction still mispredicts if the predicted target is stale.
    assign w_target_miss = w_taken & i_pred_taken & (w_target != i_pred_target);
    assign w_mispredict  = (w_taken != i_pred_taken) | w_target_miss;

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_in_valid && !i_stall && !i_flush) begin
                    w_capture = 1'b1;
                    if (w_mispredict) begin
                        w_state_next = ST_SQUASH;
                    end
                end
            end
            ST_SQUASH: begin
                // The EX occupant is wrong-path: drop it and wait for it to move on.
                if (i_flush || !i_stall) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= ST_RUN;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
            o_resolved_valid <= 1'b0;
            o_resolved_taken <= 1'b0;
            o_resolved_pc    <= '0;
            o_link_data      <= '0;
            o_illegal_cond   <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            o_redirect_valid <= w_capture & w_mispredict;
            o_resolved_valid <= w_capture;
            if (w_capture) begin
                o_redirect_pc    <= w_next_pc;
                o_resolved_taken <= w_taken;
                o_resolved_pc    <= i_pc;
                o_link_data      <= w_pc_plus4;
                o_illegal_cond   <= w_illegal;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispredict_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (w_capture) begin
            if (r_branch_cnt != 32'hFFFF_FFFF) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_mispredict && (r_mispredict_cnt != 32'hFFFF_FFFF)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

    assign o_branch_cnt     = r_branch_cnt;
    assign o_mispredict_cnt = r_mispredict_cnt;
`else
    assign o_branch_cnt     = '0;
    assign o_mispredict_cnt = '0;
`endif

endmodule
